// File: rtl/request_register_target.sv
// Register-file target behind a small request FIFO: writes retire one per cycle,
// reads park in a response state until the consumer takes the data.
module request_register_target #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    output logic                      o_s_ready,
    input  logic                      i_s_valid,
    input  logic                      i_s_command,
    input  logic [ADDR_WIDTH-1:0]     i_s_address,
    input  logic [DATA_WIDTH-1:0]     i_s_data,
    output logic                      o_r_valid,
    input  logic                      i_r_ready,
    output logic [DATA_WIDTH-1:0]     o_r_data,
    output logic                      o_r_error,
    output logic                      o_wr_error,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RESP   = 1'b1;
    localparam logic       CMD_WRITE = 1'b0;

    logic                  fifo_cmd_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_q      [NUM_REGS];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [0:0]            state_q, state_d;
    logic                  r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  r_error_q, r_error_d;
    logic                  wr_error_q, wr_error_d;

    logic                  full_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  head_cmd_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic                  head_in_range_s;
    logic [IDX_W-1:0]      head_idx_s;
    logic                  reg_we_s;

    assign full_s     = (count_q == CW'(DEPTH));
    assign o_s_ready  = ~full_s;
    assign o_count    = count_q;
    assign o_r_valid  = r_valid_q;
    assign o_r_data   = r_data_q;
    assign o_r_error  = r_error_q;
    assign o_wr_error = wr_error_q;

    // Head-of-queue decode, handshakes and pointer/occupancy next state.
    always_comb begin
        push_s          = i_s_valid & ~full_s;
        pop_s           = (state_q == ST_IDLE) && (count_q != {CW{1'b0}});
        head_cmd_s      = fifo_cmd_q[rd_ptr_q];
        head_addr_s     = fifo_addr_q[rd_ptr_q];
        head_data_s     = fifo_data_q[rd_ptr_q];
        // Widened compare so NUM_REGS == 2**ADDR_WIDTH still works.
        head_in_range_s = ({1'b0, head_addr_s} < (ADDR_WIDTH + 1)'(NUM_REGS));
        head_idx_s      = head_addr_s[IDX_W-1:0];
        reg_we_s        = pop_s && (head_cmd_s == CMD_WRITE) && head_in_range_s;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Execution FSM and response/error output next state.
    always_comb begin
        state_d    = state_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        r_error_d  = r_error_q;
        wr_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_s && (head_cmd_s != CMD_WRITE)) begin
                    state_d   = ST_RESP;
                    r_valid_d = 1'b1;
                    r_error_d = ~head_in_range_s;
                    if (head_in_range_s) begin
                        r_data_d = regs_q[head_idx_s];
                    end else begin
                        r_data_d = {DATA_WIDTH{1'b0}};
                    end
                end else if (pop_s) begin
                    wr_error_d = ~head_in_range_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                // Handshake edge only retires the response; the next pop waits a cycle.
                if (i_r_ready) begin
                    state_d   = ST_IDLE;
                    r_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                r_valid_d = 1'b0;
            end
        endcase
    end

    // Control state, pointers and response registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            state_q    <= ST_IDLE;
            r_valid_q  <= 1'b0;
            r_data_q   <= {DATA_WIDTH{1'b0}};
            r_error_q  <= 1'b0;
            wr_error_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_error_q  <= r_error_d;
            wr_error_q <= wr_error_d;
        end
    end

    // Request queue storage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_cmd_q[i]  <= 1'b0;
                fifo_addr_q[i] <= {ADDR_WIDTH{1'b0}};
                fifo_data_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            fifo_cmd_q[wr_ptr_q]  <= i_s_command;
            fifo_addr_q[wr_ptr_q] <= i_s_address;
            fifo_data_q[wr_ptr_q] <= i_s_data;
        end else begin
            fifo_cmd_q[wr_ptr_q]  <= fifo_cmd_q[wr_ptr_q];
        end
    end

    // Register file.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (reg_we_s) begin
            regs_q[head_idx_s] <= head_data_s;
        end else begin
            regs_q[head_idx_s] <= regs_q[head_idx_s];
        end
    end

endmodule

// File: tb/tb_request_register_target.sv
// Randomized and directed stimulus against an in-order register model; a
// negedge monitor scores read responses and write-error pulses from queues.
module tb_request_register_target;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NREGS = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          o_s_ready;
    logic          i_s_valid = 1'b0;
    logic          i_s_command = 1'b0;
    logic [AW-1:0] i_s_address = 8'd0;
    logic [DW-1:0] i_s_data = 32'd0;
    logic          o_r_valid;
    logic          i_r_ready = 1'b0;
    logic [DW-1:0] o_r_data;
    logic          o_r_error;
    logic          o_wr_error;
    logic [2:0]    o_count;

    request_register_target #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REGS(NREGS)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .o_s_ready(o_s_ready),
        .i_s_valid(i_s_valid), .i_s_command(i_s_command),
        .i_s_address(i_s_address), .i_s_data(i_s_data),
        .o_r_valid(o_r_valid), .i_r_ready(i_r_ready), .o_r_data(o_r_data),
        .o_r_error(o_r_error), .o_wr_error(o_wr_error), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } resp_t;

    int        n_checks = 0;
    int        n_fail = 0;
    resp_t     exp_q[$];
    int        wr_err_pending = 0;
    logic [DW-1:0] mregs [NREGS];
    bit        seen = 1'b0;
    resp_t     held;
    resp_t     e_r;
    bit        acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Requests execute in acceptance order, so the expected outcome is fixed at acceptance.
    task automatic model_accept(input bit cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit oor;
        oor = (a >= 8'(NREGS));
        if (cmd) begin
            exp_q.push_back({oor ? 32'd0 : mregs[a[3:0]], oor});
        end else if (oor) begin
            wr_err_pending++;
        end else begin
            mregs[a[3:0]] = d;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        wr_err_pending = 0;
        seen = 1'b0;
        for (int i = 0; i < NREGS; i++) mregs[i] = 32'd0;
    endtask

    task automatic drive(input bit v, input bit cmd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit rr, output bit accepted);
        @(negedge i_clk);
        i_s_valid   = v;
        i_s_command = cmd;
        i_s_address = a;
        i_s_data    = d;
        i_r_ready   = rr;
        accepted    = v && o_s_ready;
        if (accepted) model_accept(cmd, a, d);
    endtask

    task automatic drive_until(input bit cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) drive(1'b1, cmd, a, d, 1'b1, got);
        check("accept_timeout", 64'(got), 64'd1);
    endtask

    task automatic drain();
        bit got;
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, got);
            done = (o_count == 3'd0) && !o_r_valid && (exp_q.size() == 0);
        end
        check("drain_timeout", 64'(done), 64'd1);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, got);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, got);
    endtask

    // A response is consumed at a rising edge with valid and ready both high.
    always @(posedge i_clk) begin
        if (o_r_valid && i_r_ready) seen = 1'b0;
    end

    // Monitor: score each new response once, then require it to hold until taken.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_r_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_response", 64'd1, 64'd0);
                    end else begin
                        e_r = exp_q.pop_front();
                        check("r_data", 64'(o_r_data), 64'(e_r.data));
                        check("r_error", 64'(o_r_error), 64'(e_r.err));
                    end
                    held = {o_r_data, o_r_error};
                    seen = 1'b1;
                end else begin
                    check("r_hold", 64'({o_r_data, o_r_error}), 64'(held));
                end
            end
            if (o_wr_error) begin
                check("wr_error_expected", 64'(wr_err_pending > 0), 64'd1);
                if (wr_err_pending > 0) wr_err_pending--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge i_clk);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_r_valid", 64'(o_r_valid), 64'd0);
        check("rst_r_data", 64'(o_r_data), 64'd0);
        check("rst_r_error", 64'(o_r_error), 64'd0);
        check("rst_wr_error", 64'(o_wr_error), 64'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_ready", 64'(o_s_ready), 64'd1);

        // Write then read with one-cycle read latency after the pop.
        drive(1'b1, 1'b0, 8'd3, 32'hDEADBEEF, 1'b1, acc);
        check("wr3_accept", 64'(acc), 64'd1);
        drive(1'b1, 1'b1, 8'd3, 32'd0, 1'b1, acc);
        check("rd3_accept", 64'(acc), 64'd1);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, acc);
        check("rd3_not_yet_valid", 64'(o_r_valid), 64'd0);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, acc);
        check("rd3_valid_latency", 64'(o_r_valid), 64'd1);
        drain();

        // Full queue while the consumer stalls.
        drive(1'b1, 1'b1, 8'd0, 32'd0, 1'b0, acc);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 2) ? 1'b1 : 1'b0, 8'(5 + i), 32'(100 + i), 1'b0, acc);
            check("fill_accept", 64'(acc), 64'd1);
        end
        drive(1'b1, 1'b0, 8'd9, 32'd77, 1'b0, acc);
        check("full_count", 64'(o_count), 64'd4);
        check("full_ready", 64'(o_s_ready), 64'd0);
        check("full_no_accept", 64'(acc), 64'd0);
        drive(1'b1, 1'b0, 8'd9, 32'd77, 1'b0, acc);
        check("full_no_accept_stall", 64'(acc), 64'd0);
        drive(1'b1, 1'b0, 8'd9, 32'd77, 1'b1, acc);
        check("full_no_accept_handshake", 64'(acc), 64'd0);
        drive(1'b1, 1'b0, 8'd9, 32'd77, 1'b1, acc);
        check("full_no_accept_bubble", 64'(acc), 64'd0);
        drive(1'b1, 1'b0, 8'd9, 32'd77, 1'b1, acc);
        check("full_accept_after_pop", 64'(acc), 64'd1);
        drain();

        // Out-of-range write and read; addr 4 must not alias addr 20.
        drive_until(1'b0, 8'd20, 32'h1);
        drive_until(1'b1, 8'd20, 32'd0);
        drive_until(1'b1, 8'd4, 32'd0);
        drain();
        check("wr_error_seen", 64'(wr_err_pending), 64'd0);

        // Back-to-back writes must never stall.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'(i), 32'(i), 1'b1, acc);
            check("tput_accept", 64'(acc), 64'd1);
        end
        for (int i = 0; i < 8; i++) drive_until(1'b1, 8'(i), 32'd0);
        drain();

        // Random traffic with some out-of-range addresses and a stalling consumer.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(9, 0) < 7), 1'($urandom_range(1, 0)),
                  8'($urandom_range(23, 0)), $urandom(), 1'($urandom_range(1, 0)), acc);
        end
        drain();
        check("rand_wr_error_seen", 64'(wr_err_pending), 64'd0);

        // Reset while in RESP with a non-empty queue.
        drive(1'b1, 1'b1, 8'd0, 32'd0, 1'b0, acc);
        for (int k = 0; k < 20 && o_count != 3'd3; k++) begin
            drive(1'b1, 1'b0, 8'd3, 32'h55AA, 1'b0, acc);
        end
        i_s_valid = 1'b0;
        check("pre_rst_count", 64'(o_count), 64'd3);
        check("pre_rst_valid", 64'(o_r_valid), 64'd1);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_valid", 64'(o_r_valid), 64'd0);
        check("mid_rst_count", 64'(o_count), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive_until(1'b1, 8'd3, 32'd0);
        drain();

        check("leftover_responses", 64'(exp_q.size()), 64'd0);
        check("leftover_wr_errors", 64'(wr_err_pending), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
